// File: rtl/rotation_finder_if.sv
// Handshake and data bundle for rotation_finder.
// master = requester side, slave = the finder itself.
interface rotation_finder_if;
  logic       start;
  logic       select;
  logic [7:0] ent1;
  logic [7:0] ent_rot;
  logic [2:0] amount;
  logic       found;
  logic       busy;
  logic       done;

  modport master (
    output start, select, ent1, ent_rot,
    input  amount, found, busy, done
  );

  modport slave (
    input  start, select, ent1, ent_rot,
    output amount, found, busy, done
  );
endinterface

// File: rtl/rotation_finder.sv
// Finds the smallest circular rotation k (0..7) that maps ent1 onto ent_rot.
// ROTFIND_EARLY_EXIT_EN: defined = stop at first match, undefined = constant 8-cycle search.
module rotation_finder (
  input logic              clk,
  input logic              rst,
  rotation_finder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] r_k;
  logic [7:0] r_ent1;
  logic [7:0] r_ent_rot;
  logic       r_sel;
  logic [2:0] r_amount;
  logic       r_found;

  logic [15:0] w_dbl;
  logic [15:0] w_shl;
  logic [15:0] w_shr;
  logic [7:0]  w_rot;
  logic        w_match;

  // Doubling the byte turns a plain shift into a circular rotation.
  assign w_dbl   = {r_ent1, r_ent1};
  assign w_shl   = w_dbl << r_k;
  assign w_shr   = w_dbl >> r_k;
  assign w_rot   = r_sel ? w_shr[7:0] : w_shl[15:8];
  assign w_match = (w_rot == r_ent_rot);

`ifndef ROTFIND_EARLY_EXIT_EN
  logic       r_hit;
  logic [2:0] r_hit_k;
  logic       w_hit_any;
  logic [2:0] w_hit_k;

  assign w_hit_any = r_hit | w_match;
  assign w_hit_k   = r_hit ? r_hit_k : r_k;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (bus.start) w_state_next = StSearch;
      end
      StSearch: begin
`ifdef ROTFIND_EARLY_EXIT_EN
        if (w_match || (r_k == 3'd7)) w_state_next = StDone;
`else
        if (r_k == 3'd7) w_state_next = StDone;
`endif
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k       <= 3'd0;
      r_ent1    <= 8'd0;
      r_ent_rot <= 8'd0;
      r_sel     <= 1'b0;
      r_amount  <= 3'd0;
      r_found   <= 1'b0;
`ifndef ROTFIND_EARLY_EXIT_EN
      r_hit     <= 1'b0;
      r_hit_k   <= 3'd0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_ent1    <= bus.ent1;
            r_ent_rot <= bus.ent_rot;
            r_sel     <= bus.select;
            r_k       <= 3'd0;
            r_found   <= 1'b0;
`ifndef ROTFIND_EARLY_EXIT_EN
            r_hit     <= 1'b0;
`endif
          end
        end
        StSearch: begin
          r_k <= r_k + 3'd1;
`ifdef ROTFIND_EARLY_EXIT_EN
          if (w_match) begin
            r_amount <= r_k;
            r_found  <= 1'b1;
          end else if (r_k == 3'd7) begin
            r_amount <= 3'd0;
            r_found  <= 1'b0;
          end
`else
          // Remember only the first hit so the smallest k wins.
          if (w_match && !r_hit) begin
            r_hit   <= 1'b1;
            r_hit_k <= r_k;
          end
          if (r_k == 3'd7) begin
            r_amount <= w_hit_any ? w_hit_k : 3'd0;
            r_found  <= w_hit_any;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.amount = r_amount;
  assign bus.found  = r_found;
  assign bus.busy   = (r_state != StIdle);
  assign bus.done   = (r_state == StDone);

endmodule

// File: tb/tb_rotation_finder.sv
// Directed and randomized checks of rotation_finder against a loop-based reference model.
module tb_rotation_finder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rotation_finder_if bus ();

  rotation_finder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rot8(input logic [7:0] a, input int k, input logic sel);
    int ai;
    int r;
    ai = a;
    if (sel) r = ((ai >> k) | (ai << (8 - k))) & 255;
    else     r = ((ai << k) | (ai >> (8 - k))) & 255;
    return r[7:0];
  endfunction

  function automatic void ref_model(input logic [7:0] a, input logic [7:0] b, input logic sel,
                                    output logic [2:0] amt, output logic fnd, output int lat);
    amt = 3'd0;
    fnd = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!fnd && rot8(a, k, sel) == b) begin
        fnd = 1'b1;
        amt = k[2:0];
      end
    end
`ifdef ROTFIND_EARLY_EXIT_EN
    lat = fnd ? int'(amt) + 1 : 8;
`else
    lat = 8;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; issues a start on the next edge and checks the whole transaction.
  // glitch_at != 0 pulses start with junk inputs so it is sampled at edge E(glitch_at).
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic sel,
                     input int glitch_at, input string tag);
    logic [2:0] e_amt;
    logic       e_fnd;
    int         e_lat;
    int         cycles;
    bit         seen;
    ref_model(a, b, sel, e_amt, e_fnd, e_lat);
    bus.ent1    = a;
    bus.ent_rot = b;
    bus.select  = sel;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.ent1    = 8'($urandom);
    bus.ent_rot = 8'($urandom);
    bus.select  = 1'($urandom);
    check({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
    check({tag, "_found_cleared"}, 32'(bus.found), 32'd0);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 20) begin
      if (glitch_at != 0 && cycles + 1 == glitch_at) begin
        bus.start   = 1'b1;
        bus.ent1    = 8'h00;
        bus.ent_rot = 8'h00;
        bus.select  = ~sel;
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cycles), 32'(e_lat));
    check({tag, "_amount"}, 32'(bus.amount), 32'(e_amt));
    check({tag, "_found"}, 32'(bus.found), 32'(e_fnd));
    check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    check({tag, "_amount_held"}, 32'(bus.amount), 32'(e_amt));
    check({tag, "_found_held"}, 32'(bus.found), 32'(e_fnd));
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.select  = 1'b0;
    bus.ent1    = 8'h00;
    bus.ent_rot = 8'h00;

    // Reset holds idle even with start asserted.
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_amount", 32'(bus.amount), 32'd0);
    check("rst_found", 32'(bus.found), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run(8'h81, 8'h03, 1'b0, 0, "rotl_81_03");
    run(8'h81, 8'h03, 1'b1, 0, "rotr_81_03");
    run(8'h81, 8'h42, 1'b0, 0, "miss_l");
    run(8'h81, 8'h42, 1'b1, 0, "miss_r");
    run(8'h00, 8'h00, 1'b0, 0, "zero");
    run(8'hFF, 8'hFF, 1'b1, 0, "ones");
    run(8'h55, 8'hAA, 1'b0, 0, "periodic55");
    run(8'h81, 8'hC0, 1'b0, 3, "restart_ignored");

    // Reset mid-search aborts with no done strobe.
    bus.ent1    = 8'h81;
    bus.ent_rot = 8'h42;
    bus.select  = 1'b0;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_amount", 32'(bus.amount), 32'd0);
    check("abort_found", 32'(bus.found), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(8'h81, 8'h03, 1'b0, 0, "after_abort");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stray_done", 32'(bus.done), 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      a   = 8'($urandom);
      sel = 1'($urandom);
      if (i % 2 == 0) b = rot8(a, int'($urandom_range(0, 7)), sel);
      else            b = 8'($urandom);
      run(a, b, sel, 0, "random");
    end

    // Left/right amounts of a uniquely matching pair are complementary.
    run(8'h01, 8'h08, 1'b0, 0, "pair_left");
    run(8'h01, 8'h08, 1'b1, 0, "pair_right");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rotation_finder.md
ROTATION_FINDER -- requirements
Module: rotation_finder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 select  input  1  search direction: 1 = right rotation, 0 = left rotation.
REQ-006 ent1  input  8  original operand.
REQ-007 ent_rot  input  8  rotated operand whose rotation amount is to be found.
REQ-008 amount  output  3  recovered rotation amount, 0..7.
REQ-009 found  output  1  1 = amount is valid; 0 = no rotation of ent1 matches ent_rot.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle completion strobe.

Function
REQ-012 SHALL implement three states, IDLE, SEARCH and DONE, with a 3-bit candidate counter k.
REQ-013 In IDLE with start=1, at clock edge E0:
- latch ent1, ent_rot and select;
- clear k to 0;
- enter SEARCH.
REQ-014 Inputs SHALL be ignored after E0 until the block returns to IDLE; start in SEARCH or DONE has no effect.
REQ-015 In SEARCH, each cycle SHALL compare the latched ent_rot against the latched ent1 rotated by k in the latched direction; the rotation is circular, so no bits are lost.
REQ-016 On the first match in SEARCH:
- register amount=k and found=1;
- enter DONE at the edge E(k+1).
REQ-017 On no match with k<7, k SHALL increment by 1 and the block SHALL stay in SEARCH.
REQ-018 On no match with k=7:
- register amount=0 and found=0;
- enter DONE at edge E8.
REQ-019 When several k match (for example periodic patterns such as 0x00, 0xFF or 0x55), amount SHALL be the smallest matching k.
REQ-020 done SHALL equal (state==DONE) and last exactly one cycle; DONE SHALL return to IDLE on the next edge.
REQ-021 amount and found SHALL hold their values from DONE until the next accepted start, which clears found to 0 at E0.
REQ-022 Latency: done SHALL be high in the cycle between E(k+1) and E(k+2) for a match at k; worst case is E8 to E9.
REQ-023 For consistency, a left amount L and a right amount R for the same data pair SHALL satisfy R = (8-L) mod 8 when L is unique.

Reset
REQ-024 While rst=1, the block SHALL be in IDLE with k=0, amount=0, found=0, busy=0 and done=0, regardless of clk.
REQ-025 Reset asserted mid-SEARCH or in DONE SHALL abort the operation with no done strobe; the block SHALL accept a start on the first edge after rst deasserts.

Configuration
REQ-026 The macro ROTFIND_EARLY_EXIT_EN SHALL select between two timing modes:
- Defined: SEARCH exits on the first match, as described in REQ-016.
- Undefined: SEARCH always evaluates all k=0..7 and enters DONE at E8; amount and found still report the smallest match (constant-time mode).

Verification
REQ-027 ent1=0x81, ent_rot=0x03, select=0, start at E0 -> amount=1, found=1; done high between E2 and E3 (early exit) or between E8 and E9 (no early exit).
REQ-028 ent1=0x81, ent_rot=0x03, select=1 -> amount=7, found=1; done between E8 and E9 in both modes.
REQ-029 ent1=0x81, ent_rot=0x42, either select -> found=0, amount=0; done between E8 and E9.
REQ-030 ent1=0x00, ent_rot=0x00, select=0 -> amount=0, found=1; done between E1 and E2 (early exit) or between E8 and E9.
REQ-031 Start with ent1=0x81, ent_rot=0xC0, select=0; change the inputs and pulse start at E3 -> the result is still amount=7, found=1, and the second start is ignored.
REQ-032 Start a search that would end at E8, assert rst at E4 -> all outputs are 0 immediately and no done appears; a new start after reset completes normally.
